// File: rtl/crc_frame_sequencer.sv
// crc_frame_sequencer
//   Drives one external crc16_64b_parallel engine over framed 64-bit data. Each
//   accepted frame word passes straight through to the downstream stream and is
//   fed to the engine. After the frame's last word (or after MAX_WORDS words,
//   which truncates the frame), the sequencer waits CRC_LATENCY cycles for the
//   engine and then emits one trailer word {TRAILER_TAG, crc_out}. The engine is
//   held in reset while the sequencer is idle, so every frame starts from the
//   engine's init value.
module crc_frame_sequencer #(
  parameter int          CRC_LATENCY = 1,      // 1..7
  parameter int          MAX_WORDS   = 256,    // 2..65535
  parameter logic [47:0] TRAILER_TAG = 48'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [63:0] crc_din,
  output logic        crc_en,
  output logic        crc_rst,
  input  logic [15:0] crc_out,
  output logic        busy,
  output logic        err_overlen,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] TRAIL = 2'd3;

  // Index of the last word a frame may carry, and of the last wait cycle.
  localparam logic [15:0] LAST_WORD_IDX = 16'(MAX_WORDS - 1);
  localparam logic [2:0]  LAST_LAT_IDX  = 3'(CRC_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        busy_q;
  logic        err_q, err_d;
  logic        accept;
  logic        at_max;

  // Word accepted from upstream this cycle, and whether it is the frame's final allowed word.
  assign accept = (state_q == DATA) && in_valid && out_ready;
  assign at_max = (word_cnt_q == LAST_WORD_IDX);

  // Next-state logic and the combinational handshake / engine-control outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = in_data;
    crc_din     = in_data;
    crc_en      = 1'b0;
    crc_rst     = 1'b0;

    case (state_q)
      IDLE: begin
        // Engine is cleared here, so the first crc_en of a frame always follows a reset.
        crc_rst = 1'b1;
        if (in_valid) state_d = DATA;
      end

      DATA: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        crc_en    = accept;
        if (accept) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (in_last || at_max) begin
            state_d   = WAIT;
            lat_cnt_d = 3'd0;
            // A word that is both last and at the limit ends the frame normally.
            err_d     = at_max && !in_last;
          end
        end
      end

      WAIT: begin
        lat_cnt_d = lat_cnt_q + 3'd1;
        if (lat_cnt_q == LAST_LAT_IDX) state_d = TRAIL;
      end

      TRAIL: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = {TRAILER_TAG, crc_out};
        if (out_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          word_cnt_d  = 16'd0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, counters and the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      word_cnt_q  <= 16'd0;
      lat_cnt_q   <= 3'd0;
      frame_cnt_q <= 16'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= (state_d != IDLE);
      err_q       <= err_d;
    end
  end

  assign busy        = busy_q;
  assign err_overlen = err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Self-checking bench for crc_frame_sequencer. A bench-side engine model stands in
// for crc16_64b_parallel (CRC-16, poly 0x1021, init 0xFFFF, bytes fed LSB-first).
// The reference model works at frame level: it splits accepted words into frames of
// at most MAXW words, predicts the output beat stream, trailer CRCs, trailer timing,
// error pulses and the frame count, and a single monitor compares every cycle.
module tb_crc_frame_sequencer;

  localparam int          L    = 3;
  localparam int          MAXW = 4;
  localparam logic [47:0] TAG  = 48'hCAFE_F00D_0042;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [63:0] crc_din;
  logic        crc_en;
  logic        crc_rst;
  logic [15:0] crc_out;
  logic        busy;
  logic        err_overlen;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  crc_frame_sequencer #(
    .CRC_LATENCY (L),
    .MAX_WORDS   (MAXW),
    .TRAILER_TAG (TAG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .crc_din     (crc_din),
    .crc_en      (crc_en),
    .crc_rst     (crc_rst),
    .crc_out     (crc_out),
    .busy        (busy),
    .err_overlen (err_overlen),
    .frame_cnt   (frame_cnt)
  );

  // ---------------- engine model (bit-serial over the 64-bit word) ----------------
  function automatic logic [15:0] eng_word(input logic [15:0] c_in, input logic [63:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ d[8*k + b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  logic [15:0] eng_q, eng_p1, eng_p2;
  always @(posedge clk) begin
    if (crc_rst)     eng_q <= 16'hFFFF;
    else if (crc_en) eng_q <= eng_word(eng_q, crc_din);
    eng_p1 <= eng_q;
    eng_p2 <= eng_p1;
  end
  assign crc_out = eng_p2;   // valid L=3 cycles after the last crc_en

  // ---------------- reference CRC over a byte stream ----------------
  function automatic logic [15:0] ref_crc(input logic [7:0] bytes[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (bytes[i]) begin
      c = c ^ {bytes[i], 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- frame-level reference model ----------------
  logic [64:0] exp_q[$];        // {last, data} expected output beats
  int          trail_cyc_q[$];  // cycle each trailer must first appear
  logic [7:0]  chunk_bytes[$];  // bytes of the frame currently being collected
  int          chunk_pos;
  logic [15:0] model_frames;
  logic        err_due;
  int          err_seen = 0;
  int          crc_en_seen = 0;
  logic        trail_pending;
  logic [63:0] trail_hold;
  logic [64:0] log_q[$];        // every accepted output beat
  logic [64:0] mon_e;
  bit          mon_en = 0;

  task automatic model_clear();
    exp_q.delete();
    trail_cyc_q.delete();
    chunk_bytes.delete();
    chunk_pos     = 0;
    model_frames  = 16'h0000;
    err_due       = 1'b0;
    trail_pending = 1'b0;
  endtask

  // Monitor: compares every cycle, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        check("busy_vs_crc_rst", 64'(busy), 64'(!crc_rst));
        check("crc_en", 64'(crc_en), 64'(in_valid && in_ready));
        if (crc_en) begin
          crc_en_seen++;
          check("crc_din", crc_din, in_data);
        end
        check("frame_cnt", 64'(frame_cnt), 64'(model_frames));
        check("err_overlen", 64'(err_overlen), 64'(err_due));
        if (err_overlen) err_seen++;
        err_due = 1'b0;

        // Accepted input word: passes through and joins the current frame.
        if (in_valid && in_ready) begin
          exp_q.push_back({1'b0, in_data});
          for (int k = 0; k < 8; k++) chunk_bytes.push_back(in_data[8*k +: 8]);
          chunk_pos++;
          if (in_last || chunk_pos == MAXW) begin
            exp_q.push_back({1'b1, TAG, ref_crc(chunk_bytes)});
            trail_cyc_q.push_back(cyc + L + 1);
            err_due = !in_last && (chunk_pos == MAXW);
            chunk_bytes.delete();
            chunk_pos = 0;
          end
        end

        // Trailer timing and stability while it waits for out_ready.
        if (trail_pending) begin
          check("trailer_held_valid", 64'(out_valid && out_last), 64'd1);
          check("trailer_held_data", out_data, trail_hold);
        end else if (out_valid && out_last) begin
          if (trail_cyc_q.size() == 0) fail_now("trailer_unexpected");
          else check("trailer_latency", 64'(cyc), 64'(trail_cyc_q[0]));
          trail_pending = 1'b1;
          trail_hold    = out_data;
        end

        // Output transfer against the predicted beat stream.
        if (out_valid && out_ready) begin
          log_q.push_back({out_last, out_data});
          if (exp_q.size() == 0) begin
            fail_now("out_beat_unexpected");
          end else begin
            mon_e = exp_q.pop_front();
            check("out_data", out_data, mon_e[63:0]);
            check("out_last", 64'(out_last), 64'(mon_e[64]));
          end
          if (out_last) begin
            model_frames++;
            trail_pending = 1'b0;
            if (trail_cyc_q.size() != 0) void'(trail_cyc_q.pop_front());
          end
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = toggles every cycle, 2 = random.
  int rmode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [63:0] d, input logic last, input int gap);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("in_ready_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));   // must be ignored while in_valid=0
    in_data  = {$urandom, $urandom};
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++)
      send_word({$urandom, $urandom}, (i == n - 1), gaps ? $urandom_range(0, 2) : 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy || trail_pending) && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (t >= 300) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the bench must always terminate.
  initial begin
    #400000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [7:0]  pin_q[$];
  logic [15:0] fc0;
  int          err0;
  int          en0;

  initial begin
    in_valid  = 1'b0;
    in_data   = 64'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    model_clear();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_crc_rst", 64'(crc_rst), 64'd1);
    check("rst_crc_en", 64'(crc_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err_overlen), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

    // Pin the reference CRC: CRC-16/CCITT-FALSE check value of "123456789".
    pin_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("ref_crc_check_value", 64'(ref_crc(pin_q)), 64'h29B1);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;

    // Directed 2-word frame, downstream always ready.
    log_q.delete();
    send_word(64'h123456789abcdef0, 1'b0, 0);
    send_word(64'h1234000056780000, 1'b1, 0);
    drain();
    pin_q = '{8'hf0, 8'hde, 8'hbc, 8'h9a, 8'h78, 8'h56, 8'h34, 8'h12,
              8'h00, 8'h00, 8'h78, 8'h56, 8'h00, 8'h00, 8'h34, 8'h12};
    check("two_word_beats", 64'(log_q.size()), 64'd3);
    if (log_q.size() >= 3) begin
      check("two_word_w0", log_q[0][63:0], 64'h123456789abcdef0);
      check("two_word_w0_last", 64'(log_q[0][64]), 64'd0);
      check("two_word_w1", log_q[1][63:0], 64'h1234000056780000);
      check("two_word_w1_last", 64'(log_q[1][64]), 64'd0);
      check("two_word_trl_last", 64'(log_q[2][64]), 64'd1);
      check("two_word_trl_tag", 64'(log_q[2][63:16]), 64'hCAFE_F00D_0042);
      check("two_word_trl_crc", 64'(log_q[2][15:0]), 64'(ref_crc(pin_q)));
    end
    check("two_word_frame_cnt", 64'(frame_cnt), 64'd1);

    // Asynchronous reset in the middle of a frame discards it.
    send_word(64'h0BAD_F00D_DEAD_BEEF, 1'b0, 0);
    @(negedge clk);
    check("mid_frame_busy", 64'(busy), 64'd1);
    #1;
    mon_en = 0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_crc_rst", 64'(crc_rst), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;

    // Backpressure: out_ready toggles through DATA and TRAIL.
    en0   = crc_en_seen;
    rmode = 1;
    send_frame(2, 0);
    drain();
    rmode = 0;
    check("bp_crc_en_count", 64'(crc_en_seen - en0), 64'd2);

    // Overlength: 6 words with last on word 6 and MAXW=4 -> two frames.
    err0 = err_seen;
    fc0  = frame_cnt;
    send_frame(6, 0);
    drain();
    check("overlen_err_pulses", 64'(err_seen - err0), 64'd1);
    check("overlen_frames", 64'(16'(frame_cnt - fc0)), 64'd2);

    // Back-to-back single-word frames (trailer timing checked by the monitor).
    fc0 = frame_cnt;
    for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 1'b1, 0);
    drain();
    check("b2b_frames", 64'(16'(frame_cnt - fc0)), 64'd5);

    // Randomized frames, gaps and downstream readiness.
    rmode = 2;
    for (int f = 0; f < 40; f++) send_frame($urandom_range(1, 9), $urandom_range(0, 1) == 1);
    drain();
    rmode = 0;
    drain();

    // frame_cnt wraps from 16'hFFFF to 0.
    @(posedge clk);
    #2;
    force dut.frame_cnt_q = 16'hFFFF;
    model_frames = 16'hFFFF;
    @(posedge clk);
    #2;
    release dut.frame_cnt_q;
    send_word({$urandom, $urandom}, 1'b1, 0);
    drain();
    check("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
